// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding-request instruction fetch controller.
// Issues one instruction-memory read at a time, holds the returned word
// for decode until it is consumed, and handles flush/redirect requests,
// including redirects that arrive while a read is still in flight.
//
// Ports:
//   clk          in   system clock, rising-edge
//   reset        in   asynchronous active-low reset
//   stall        in   decode cannot accept the held instruction this cycle
//   npc          in   next-PC for the held instruction
//   redirect     in   flush request (priority over stall and ack)
//   redirect_pc  in   redirect target address
//   imem_req     out  instruction-memory read request
//   imem_addr    out  instruction-memory read address
//   imem_ack     in   read data valid this cycle
//   imem_rdata   in   read data
//   pc           out  address of the instruction on instr
//   instr        out  held instruction word
//   instr_valid  out  instr/pc valid for decode
//   stall_cnt    out  saturating count of stalled valid cycles
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | read request outstanding at pc_q
// S_VALID | instruction held for decode
// S_DROP  | read outstanding whose data is discarded; tgt_q is the
//         | address to fetch once it completes
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      instr_q <= 32'h0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            // Read already completed: drop it and refetch at the target now.
            pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          pc_d    = npc;
          state_d = S_FETCH;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DROP: begin
        if (redirect) begin
          tgt_d = redirect_pc;
          if (imem_ack) begin
            pc_d    = redirect_pc;
            state_d = S_FETCH;
          end
        end else if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Request is gated by reset so it drops the instant reset asserts and
  // rises as soon as reset releases (state is already S_FETCH).
  assign imem_req    = reset && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_VALID);
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc         (npc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs driven before the rising edge, outputs sampled at
  // the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; npc = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", instr_valid); end
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL rst_pc got %h exp 00003000", pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", stall_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      errors++; $display("FAIL first_req got req=%0h addr=%h exp req=1 addr=00003000", imem_req, imem_addr);
    end
  endtask

  task automatic test_fetch();
    step(); step();
    imem_ack = 1'b1; imem_rdata = 32'h3C01_1234; npc = 32'h3004;
    step();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h3000 || instr !== 32'h3C01_1234) begin
      errors++; $display("FAIL fetch_valid got v=%0h pc=%h instr=%h exp v=1 pc=00003000 instr=3c011234", instr_valid, pc, instr);
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_in_valid got %0h exp 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_next got req=%0h addr=%h v=%0h exp req=1 addr=00003004 v=0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001; stall = 1'b1; npc = 32'h3008;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h3004 || instr !== 32'hAAAA_0001) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%0h req=%0h pc=%h instr=%h exp v=1 req=0 pc=00003004 instr=aaaa0001",
                           i, instr_valid, imem_req, pc, instr);
      end
    end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
    stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
      errors++; $display("FAIL stall_release got req=%0h addr=%h exp req=1 addr=00003008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_fetch();
    redirect = 1'b1; redirect_pc = 32'h4180;
    step();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drop_entry got req=%0h v=%0h exp req=0 v=0", imem_req, instr_valid);
    end
    step(); step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4180) begin
      errors++; $display("FAIL redir_fetch got v=%0h req=%0h addr=%h exp v=0 req=1 addr=00004180", instr_valid, imem_req, imem_addr);
    end
    checks++; if (instr !== 32'hAAAA_0001 || stall_cnt !== 16'd5) begin
      errors++; $display("FAIL redir_fetch_hold got instr=%h cnt=%0d exp instr=aaaa0001 cnt=5", instr, stall_cnt);
    end
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000; redirect = 1'b1; redirect_pc = 32'h3100;
    step();
    imem_ack = 1'b0; redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3100 || instr !== 32'hAAAA_0001) begin
      errors++; $display("FAIL redir_ack got v=%0h req=%0h addr=%h instr=%h exp v=0 req=1 addr=00003100 instr=aaaa0001",
                         instr_valid, imem_req, imem_addr, instr);
    end
  endtask

  task automatic test_drop_redirect();
    redirect = 1'b1; redirect_pc = 32'h6000;
    step();
    redirect_pc = 32'h5000;
    step();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drop_hold got req=%0h v=%0h exp req=0 v=0", imem_req, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drop_latest got req=%0h addr=%h v=%0h exp req=1 addr=00005000 v=0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_valid_redirect();
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222; npc = 32'h5004;
    step();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h5000 || instr !== 32'h1111_2222) begin
      errors++; $display("FAIL vr_valid got v=%0h pc=%h instr=%h exp v=1 pc=00005000 instr=11112222", instr_valid, pc, instr);
    end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h7000;
    step();
    stall = 1'b0; redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h7000 || stall_cnt !== 16'd5) begin
      errors++; $display("FAIL vr_redirect got req=%0h addr=%h cnt=%0d exp req=1 addr=00007000 cnt=5", imem_req, imem_addr, stall_cnt);
    end
  endtask

  task automatic test_saturate_and_reset();
    imem_ack = 1'b1; imem_rdata = 32'h7777_0000; npc = 32'h7004;
    step();
    imem_ack = 1'b0; stall = 1'b1;
    repeat (65530) step();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", stall_cnt); end
    step(); step();
    checks++; if (stall_cnt !== 16'hFFFF || instr_valid !== 1'b1) begin
      errors++; $display("FAIL sat_hold got cnt=%h v=%0h exp cnt=ffff v=1", stall_cnt, instr_valid);
    end
    stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h7004) begin
      errors++; $display("FAIL sat_release got req=%0h addr=%h exp req=1 addr=00007004", imem_req, imem_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h3000 || imem_addr !== 32'h3000) begin
      errors++; $display("FAIL async_rst_ctl got req=%0h v=%0h pc=%h addr=%h exp req=0 v=0 pc=00003000 addr=00003000",
                         imem_req, instr_valid, pc, imem_addr);
    end
    checks++; if (instr !== 32'h0 || stall_cnt !== 16'h0) begin
      errors++; $display("FAIL async_rst_data got instr=%h cnt=%h exp instr=0 cnt=0", instr, stall_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      errors++; $display("FAIL rst_refetch got req=%0h addr=%h exp req=1 addr=00003000", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_fetch();
    test_redirect_ack();
    test_drop_redirect();
    test_valid_redirect();
    test_saturate_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard stall from decode; 1 = decode cannot accept an instruction this cycle.
REQ-005 npc  input  32  next-PC value for the instruction currently held, computed by next-PC logic.
REQ-006 redirect  input  1  flush request; discards any in-flight or held fetch.
REQ-007 redirect_pc  input  32  target address accompanying redirect.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  instruction-memory read address.
REQ-010 imem_ack  input  1  read data valid on imem_rdata this cycle; never asserted without an outstanding request.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 pc  output  32  address of the instruction on instr.
REQ-013 instr  output  32  fetched instruction word.
REQ-014 instr_valid  output  1  instr and pc are valid for decode.
REQ-015 stall_cnt  output  16  count of cycles with instr_valid=1 and stall=1, saturating.

Function
REQ-016 States: FETCH (request outstanding), VALID (instruction held for decode), DROP (request outstanding, result to be discarded).
REQ-017 Internal 32-bit registers: pc_q (fetch address) and tgt_q (pending redirect target).
REQ-018 FETCH: imem_req=1, imem_addr=pc_q, instr_valid=0.
REQ-019 FETCH, imem_ack=1, redirect=0: instr<=imem_rdata, go to VALID next cycle; zero-bubble path is not required.
REQ-020 FETCH, redirect=1, imem_ack=0: tgt_q<=redirect_pc, go to DROP.
REQ-021 FETCH, redirect=1, imem_ack=1: discard imem_rdata, pc_q<=redirect_pc, stay in FETCH.
REQ-022 VALID: imem_req=0, instr_valid=1, pc=pc_q.
REQ-023 VALID, stall=0, redirect=0: instruction consumed; pc_q<=npc, go to FETCH.
REQ-024 VALID, stall=1, redirect=0: hold pc_q and instr unchanged; stall_cnt increments unless at 16'hFFFF.
REQ-025 VALID, redirect=1: pc_q<=redirect_pc, go to FETCH regardless of stall; no consumption occurs and stall_cnt does not increment.
REQ-026 DROP: imem_req=0, instr_valid=0; on imem_ack=1, discard data, pc_q<=tgt_q, go to FETCH.
REQ-027 DROP, redirect=1: tgt_q<=redirect_pc (latest redirect wins); if imem_ack=1 in the same cycle, pc_q<=redirect_pc directly.
REQ-028 Redirect has priority over stall and over a completing ack in every state.
REQ-029 pc_q and npc are not range-checked; pc_q+4 arithmetic is not performed internally and wraps modulo 2^32 only as supplied via npc.
REQ-030 Outputs pc and instr hold their last values when instr_valid=0; consumers ignore them.

Reset
REQ-031 While reset=0: state=FETCH, pc_q=RESET_PC, tgt_q=0, instr=0, stall_cnt=0, instr_valid=0, imem_req=0.
REQ-032 Reset assertion takes effect immediately and asynchronously, abandoning any outstanding request; an imem_ack arriving after reset release that belongs to a pre-reset request is the memory's responsibility to suppress.
REQ-033 The first imem_req=1 with imem_addr=RESET_PC occurs in the first cycle after reset deasserts.

Verification
REQ-034 Release reset, ack after 2 cycles with rdata=32'h3C01_1234, stall=0, npc=32'h3004 -> instr_valid=1 with pc=32'h3000, next request imem_addr=32'h3004.
REQ-035 In VALID hold stall=1 for 5 cycles -> instr, pc unchanged, stall_cnt=5, imem_req=0 throughout.
REQ-036 In FETCH, pulse redirect with redirect_pc=32'h4180 before ack; ack 3 cycles later -> no instr_valid for that data; next imem_addr=32'h4180.
REQ-037 Redirect and ack in the same FETCH cycle (redirect_pc=32'h3100) -> data dropped, next cycle imem_addr=32'h3100.
REQ-038 In DROP, second redirect to 32'h5000 before ack -> after ack, imem_addr=32'h5000 (not the first target).
REQ-039 Force stall_cnt to 16'hFFFF via long stall, stall 2 more cycles -> stall_cnt stays 16'hFFFF; assert reset mid-FETCH -> all outputs return to REQ-031 values immediately.
